speed_sel_ctrl: RTL

SPEED_SEL_CTRL -- requirements
Module: speed_sel_ctrl

---
 rtl/speed_sel_pkg.sv | 27 ++
 rtl/sync_ff.sv | 25 ++
 rtl/speed_sel_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/speed_sel_pkg.sv
// Shared definitions for the clock speed selection controller:
// FSM state encoding, configuration register field layout and reset value.
package speed_sel_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_LS_RUN  = 3'd0;
  localparam logic [2:0] ST_HS_REQ  = 3'd1;
  localparam logic [2:0] ST_HS_RUN  = 3'd2;
  localparam logic [2:0] ST_LS_REQ  = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // Configuration register layout: {timeout_err/clear, holdoff[3:0], div[1:0], turbo_en}
  localparam int CFG_TURBO_BIT = 0;
  localparam int CFG_DIV_LSB   = 1;
  localparam int CFG_DIV_W     = 2;
  localparam int CFG_HOLD_LSB  = 3;
  localparam int CFG_HOLD_W    = 4;
  localparam int CFG_CLR_BIT   = 7;

  localparam logic [7:0] CFG_RESET = 8'h00;

  // True in the states where the clock request line is high
  function automatic logic isFastState(input logic [2:0] state);
    return (state == ST_HS_REQ) || (state == ST_HS_RUN);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser bringing a single asynchronous bit into the
// receiving clock domain. STAGES must be 2 or more.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_b,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/speed_sel_ctrl.sv
// Speed selection controller: hands the CPU clock between the slow host
// clock and the fast clock via a request/acknowledge handshake with the
// clock controller, with a configurable hold-off before returning to the
// slow-clock run state.
// Optional feature: define CLKSEL_TIMEOUT_EN to add a handshake timeout
// that raises a sticky error, drops turbo mode and forces a return to slow.
module speed_sel_ctrl
  import speed_sel_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       lsclk_in,
  input  logic       rst_b,
  input  logic       host_req,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_wdata,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic [7:0] cfg_rdata,
  output logic       timeout_err
);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic       r_turbo_en;
  logic [1:0] r_div;
  logic [3:0] r_holdoff;
  logic [3:0] r_hold_cnt;
  logic [3:0] w_hold_cnt_nxt;
  logic       r_hsclk_sel;
  logic [1:0] r_cpuclk_div_sel;
  logic       w_hs_ack;
  logic       w_timeout;
  logic       w_timeout_err;
  logic       w_abort;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_hs_ack_sync (
    .i_clk  (lsclk_in),
    .i_rst_b(rst_b),
    .i_d    (hsclk_selected),
    .o_q    (w_hs_ack)
  );

  // Leaving fast mode is wanted when the host bus is needed or turbo is off
  assign w_abort = host_req || !r_turbo_en;

`ifdef CLKSEL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;
  logic            w_waiting;

  assign w_waiting = (r_state == ST_HS_REQ) || (r_state == ST_LS_REQ);
  assign w_timeout = w_waiting && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting for a handshake; restart on any state change
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_to_cnt <= '0;
    end else if (w_waiting && (w_state_nxt == r_state) && !w_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Sticky error flag: a timeout wins over a simultaneous clear write
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_timeout_err <= CFG_RESET[CFG_CLR_BIT];
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (cfg_wr && cfg_wdata[CFG_CLR_BIT]) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign w_timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;

  assign w_timeout     = 1'b0;
  assign w_timeout_err = 1'b0;
  assign w_unused_cfg  = cfg_wdata[CFG_CLR_BIT] ^ (TIMEOUT_CYCLES > 0);
`endif

  // Next-state and hold-off counter logic
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_LS_RUN: begin
        if (r_turbo_en && !host_req && lsclk_selected) begin
          w_state_nxt = ST_HS_REQ;
        end
      end
      ST_HS_REQ: begin
        if (w_abort || w_timeout) begin
          w_state_nxt = ST_LS_REQ;
        end else if (w_hs_ack) begin
          w_state_nxt = ST_HS_RUN;
        end
      end
      ST_HS_RUN: begin
        if (w_abort) begin
          w_state_nxt = ST_LS_REQ;
        end
      end
      ST_LS_REQ: begin
        if (lsclk_selected && !w_hs_ack) begin
          if (r_holdoff != 4'd0) begin
            w_state_nxt    = ST_HOLDOFF;
            w_hold_cnt_nxt = r_holdoff;
          end else begin
            w_state_nxt = ST_LS_RUN;
          end
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt <= 4'd1) begin
          w_state_nxt    = ST_LS_RUN;
          w_hold_cnt_nxt = 4'd0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt    = ST_LS_RUN;
        w_hold_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State, hold-off counter and registered clock request
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= ST_LS_RUN;
      r_hold_cnt  <= 4'd0;
      r_hsclk_sel <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_hsclk_sel <= isFastState(w_state_nxt);
    end
  end

  // Configuration fields; a timeout forces turbo mode off
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_turbo_en <= CFG_RESET[CFG_TURBO_BIT];
      r_div      <= CFG_RESET[CFG_DIV_LSB +: CFG_DIV_W];
      r_holdoff  <= CFG_RESET[CFG_HOLD_LSB +: CFG_HOLD_W];
    end else begin
      if (cfg_wr) begin
        r_turbo_en <= cfg_wdata[CFG_TURBO_BIT];
        r_div      <= cfg_wdata[CFG_DIV_LSB +: CFG_DIV_W];
        r_holdoff  <= cfg_wdata[CFG_HOLD_LSB +: CFG_HOLD_W];
      end
      if (w_timeout) begin
        r_turbo_en <= 1'b0;
      end
    end
  end

  // Divider changes only while the CPU is safely running on the slow clock
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_cpuclk_div_sel <= 2'b00;
    end else if (((r_state == ST_LS_RUN) || (r_state == ST_HOLDOFF)) && lsclk_selected) begin
      r_cpuclk_div_sel <= r_div;
    end
  end

  assign hsclk_sel      = r_hsclk_sel;
  assign cpuclk_div_sel = r_cpuclk_div_sel;
  assign timeout_err    = w_timeout_err;
  assign cfg_rdata      = {w_timeout_err, r_holdoff, r_div, r_turbo_en};

endmodule
